// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
//   Shared definitions for the UART receive/transmit pair:
//     - receiver state encodings (uart_state_t)
//     - default clock frequency and bit rate
//     - bit-period derivation helpers (CLKS_PER_BIT, HALF_BIT)
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int unsigned DEF_CLK_FREQ = 50_000_000;
    localparam int unsigned DEF_BAUD     = 115_200;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_HIGH = 3'd5
    } uart_state_t;

    // Integer bit period in clock cycles (truncating).
    function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                                 input int unsigned baud);
        return clk_freq / baud;
    endfunction

    function automatic int unsigned half_bit(input int unsigned clk_freq,
                                             input int unsigned baud);
        return clks_per_bit(clk_freq, baud) / 2;
    endfunction

    localparam int unsigned DEF_CLKS_PER_BIT = clks_per_bit(DEF_CLK_FREQ, DEF_BAUD);
    localparam int unsigned DEF_HALF_BIT     = half_bit(DEF_CLK_FREQ, DEF_BAUD);

endpackage

// File: rtl/uart_sync.sv
// ---------------------------------------------------------------------------
// uart_sync
//   Two-flop synchronizer for the asynchronous serial line. Both flops reset
//   to 1 (line idle level) so reset never looks like a start bit.
//   Ports:
//     clk_50M  - clock
//     reset    - synchronous active-high reset
//     async_in - asynchronous input
//     sync_out - synchronized output
// ---------------------------------------------------------------------------
module uart_sync (
    input  logic clk_50M,
    input  logic reset,
    input  logic async_in,
    output logic sync_out
);

    logic meta;

    always_ff @(posedge clk_50M) begin
        if (reset) begin
            meta     <= 1'b1;
            sync_out <= 1'b1;
        end else begin
            meta     <= async_in;
            sync_out <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
//   UART receiver, 8 data bits LSB first, 1 stop bit. Start bit is verified at
//   mid-bit; data and stop bits are sampled one bit period apart from there.
//   Optional even parity bit when UART_RX_PARITY_EN is defined (8E1),
//   otherwise 8N1 with parity_err tied low.
//   Ports:
//     clk_50M     - clock, all logic on rising edge
//     reset       - synchronous active-high reset
//     rx_raw      - asynchronous serial line, idle high
//     data_out    - last correctly received byte
//     data_valid  - one-cycle pulse when data_out is updated
//     rx_busy     - high from start detection until return to idle
//     framing_err - one-cycle pulse on a stop bit sampled low
//     parity_err  - one-cycle pulse on parity mismatch (0 without parity)
// ---------------------------------------------------------------------------
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = DEF_CLK_FREQ,
    parameter int unsigned BAUD     = DEF_BAUD
) (
    input  logic       clk_50M,
    input  logic       reset,
    input  logic       rx_raw,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       rx_busy,
    output logic       framing_err,
    output logic       parity_err
);

    localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
    localparam int unsigned HALF_BIT     = half_bit(CLK_FREQ, BAUD);

    if (CLKS_PER_BIT < 4 || CLKS_PER_BIT > 65535) begin : g_bad_baud
        $error("uart_rx: CLKS_PER_BIT out of range 4..65535");
    end

    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST = 16'(HALF_BIT - 1);

    logic        rx_sync;
    uart_state_t state;
    logic [15:0] timer;
    logic [2:0]  bit_idx;
    logic [7:0]  shift;
    logic        stop_ok;   // stop bit good this cycle; data_valid follows

`ifdef UART_RX_PARITY_EN
    logic        par_bad;
    logic        par_err_q;
    assign parity_err = par_err_q;
`else
    assign parity_err = 1'b0;
`endif

    uart_sync u_sync (
        .clk_50M  (clk_50M),
        .reset    (reset),
        .async_in (rx_raw),
        .sync_out (rx_sync)
    );

    always_ff @(posedge clk_50M) begin
        if (reset) begin
            state       <= ST_IDLE;
            timer       <= '0;
            bit_idx     <= '0;
            shift       <= '0;
            data_out    <= '0;
            data_valid  <= 1'b0;
            stop_ok     <= 1'b0;
            rx_busy     <= 1'b0;
            framing_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad     <= 1'b0;
            par_err_q   <= 1'b0;
`endif
        end else begin
            data_valid  <= stop_ok;
            stop_ok     <= 1'b0;
            framing_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err_q   <= 1'b0;
`endif
            timer       <= timer + 16'd1;

            case (state)
                ST_IDLE: begin
                    timer <= '0;
                    if (!rx_sync) begin
                        state   <= ST_START;
                        rx_busy <= 1'b1;
`ifdef UART_RX_PARITY_EN
                        par_bad <= 1'b0;
`endif
                    end
                end

                ST_START: begin
                    if (timer == HALF_LAST) begin
                        timer <= '0;
                        if (rx_sync) begin
                            state   <= ST_IDLE;
                            rx_busy <= 1'b0;
                        end else begin
                            state   <= ST_DATA;
                            bit_idx <= '0;
                        end
                    end
                end

                ST_DATA: begin
                    if (timer == BIT_LAST) begin
                        timer   <= '0;
                        shift   <= {rx_sync, shift[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= ST_PARITY;
`else
                            state <= ST_STOP;
`endif
                        end
                    end
                end

`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (timer == BIT_LAST) begin
                        timer   <= '0;
                        par_bad <= ^{shift, rx_sync};
                        state   <= ST_STOP;
                    end
                end
`endif

                ST_STOP: begin
                    if (timer == BIT_LAST) begin
                        timer <= '0;
                        if (rx_sync) begin
                            // Leave at mid stop bit so a following start bit
                            // with zero idle time is still caught.
                            state   <= ST_IDLE;
                            rx_busy <= 1'b0;
`ifdef UART_RX_PARITY_EN
                            if (par_bad) begin
                                par_err_q <= 1'b1;
                            end else begin
                                data_out <= shift;
                                stop_ok  <= 1'b1;
                            end
`else
                            data_out <= shift;
                            stop_ok  <= 1'b1;
`endif
                        end else begin
                            framing_err <= 1'b1;
                            state       <= ST_WAIT_HIGH;
                        end
                    end
                end

                ST_WAIT_HIGH: begin
                    timer <= '0;
                    if (rx_sync) begin
                        state   <= ST_IDLE;
                        rx_busy <= 1'b0;
                    end
                end

                default: begin
                    state   <= ST_IDLE;
                    timer   <= '0;
                    rx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx
//   Directed bench for uart_rx at a scaled bit rate: CLK_FREQ 50 MHz,
//   BAUD 1_200_000 -> CLKS_PER_BIT = 41 (truncated from 41.67), HALF_BIT = 20.
//   Define UART_RX_PARITY_EN to exercise the 8E1 build.
// ---------------------------------------------------------------------------
module tb_uart_rx;

    localparam int CPB  = 41;
    localparam int HALF = 20;
`ifdef UART_RX_PARITY_EN
    localparam int LAT  = HALF + 9 * CPB + 1 + CPB;   // 431
`else
    localparam int LAT  = HALF + 9 * CPB + 1;         // 390
`endif

    logic       clk_50M;
    logic       reset;
    logic       rx_raw;
    logic [7:0] data_out;
    logic       data_valid;
    logic       rx_busy;
    logic       framing_err;
    logic       parity_err;

    int tests_run;
    int tests_failed;

    uart_rx #(
        .CLK_FREQ (50_000_000),
        .BAUD     (1_200_000)
    ) dut (
        .clk_50M     (clk_50M),
        .reset       (reset),
        .rx_raw      (rx_raw),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .rx_busy     (rx_busy),
        .framing_err (framing_err),
        .parity_err  (parity_err)
    );

    initial clk_50M = 1'b0;
    always #10 clk_50M = ~clk_50M;

    // Cycle counter and output monitor
    int         cyc;
    int         n_valid, n_valid_cyc, n_ferr, n_ferr_cyc, n_perr, n_perr_cyc;
    int         n_overlap, busy_cycles, busy_rise_cyc, valid_cyc;
    logic [7:0] rx_q[$];
    logic       dv_prev, fe_prev, pe_prev, busy_prev;

    initial begin
        cyc = 0; dv_prev = 0; fe_prev = 0; pe_prev = 0; busy_prev = 0;
        busy_rise_cyc = 0; valid_cyc = 0;
    end

    always @(posedge clk_50M) cyc <= cyc + 1;

    always @(negedge clk_50M) begin
        if (data_valid) begin
            n_valid_cyc++;
            if (!dv_prev) begin
                n_valid++;
                rx_q.push_back(data_out);
                valid_cyc = cyc;
            end
        end
        if (framing_err) begin
            n_ferr_cyc++;
            if (!fe_prev) n_ferr++;
        end
        if (parity_err) begin
            n_perr_cyc++;
            if (!pe_prev) n_perr++;
        end
        if (int'(data_valid) + int'(framing_err) + int'(parity_err) > 1) n_overlap++;
        if (rx_busy) begin
            busy_cycles++;
            if (!busy_prev) busy_rise_cyc = cyc;
        end
        dv_prev   = data_valid;
        fe_prev   = framing_err;
        pe_prev   = parity_err;
        busy_prev = rx_busy;
    end

    task automatic clear_counts();
        n_valid = 0; n_valid_cyc = 0; n_ferr = 0; n_ferr_cyc = 0;
        n_perr = 0; n_perr_cyc = 0; n_overlap = 0; busy_cycles = 0;
        rx_q.delete();
    endtask

    task automatic drive_bit(input logic v);
        rx_raw = v;
        repeat (CPB) @(posedge clk_50M);
        #1;
    endtask

    task automatic idle_bits(input int n);
        rx_raw = 1'b1;
        repeat (n * CPB) @(posedge clk_50M);
        #1;
    endtask

    // Parity bit is only put on the line in the parity build.
    task automatic send_frame(input logic [7:0] b, input logic par, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(par);
`else
        if (par === 1'bx) rx_raw = 1'b1;
`endif
        drive_bit(stop);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_frame(b, ^b, 1'b1);
    endtask

    task automatic test_reset();
        reset = 1'b1; rx_raw = 1'b1;
        repeat (4) @(posedge clk_50M);
        @(negedge clk_50M);
        tests_run++;
        if (data_out !== 8'h00) begin tests_failed++; $display("FAIL reset_data_out: got %h want 00", data_out); end
        tests_run++;
        if (data_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_data_valid: got %b want 0", data_valid); end
        tests_run++;
        if (rx_busy !== 1'b0) begin tests_failed++; $display("FAIL reset_rx_busy: got %b want 0", rx_busy); end
        tests_run++;
        if (framing_err !== 1'b0) begin tests_failed++; $display("FAIL reset_framing_err: got %b want 0", framing_err); end
        tests_run++;
        if (parity_err !== 1'b0) begin tests_failed++; $display("FAIL reset_parity_err: got %b want 0", parity_err); end
        reset = 1'b0;
        @(posedge clk_50M); #1;
        idle_bits(2);
        clear_counts();
    endtask

    task automatic test_single_byte();
        clear_counts();
        send_byte(8'h48);
        idle_bits(2);
        tests_run++;
        if (n_valid !== 1) begin tests_failed++; $display("FAIL single_valid_count: got %0d want 1", n_valid); end
        tests_run++;
        if (n_valid_cyc !== 1) begin tests_failed++; $display("FAIL single_valid_width: got %0d cycles want 1", n_valid_cyc); end
        tests_run++;
        if (data_out !== 8'h48) begin tests_failed++; $display("FAIL single_data_out: got %h want 48", data_out); end
        tests_run++;
        if (valid_cyc - busy_rise_cyc !== LAT) begin
            tests_failed++; $display("FAIL single_latency: got %0d want %0d", valid_cyc - busy_rise_cyc, LAT);
        end
        tests_run++;
        if (rx_busy !== 1'b0) begin tests_failed++; $display("FAIL single_busy_after: got %b want 0", rx_busy); end
        tests_run++;
        if (n_ferr + n_perr !== 0) begin tests_failed++; $display("FAIL single_errors: got %0d want 0", n_ferr + n_perr); end
    endtask

    task automatic test_back_to_back();
        string msg;
        logic [7:0] exp;
        msg = "Hello World!    ";
        clear_counts();
        for (int i = 0; i < 16; i++) send_byte(msg[i]);
        idle_bits(2);
        tests_run++;
        if (n_valid !== 16) begin tests_failed++; $display("FAIL b2b_count: got %0d want 16", n_valid); end
        for (int i = 0; i < 16; i++) begin
            exp = msg[i];
            tests_run++;
            if (i >= rx_q.size()) begin
                tests_failed++; $display("FAIL b2b_byte%0d: missing want %h", i, exp);
            end else if (rx_q[i] !== exp) begin
                tests_failed++; $display("FAIL b2b_byte%0d: got %h want %h", i, rx_q[i], exp);
            end
        end
        tests_run++;
        if (n_ferr + n_perr !== 0) begin tests_failed++; $display("FAIL b2b_errors: got %0d want 0", n_ferr + n_perr); end
        tests_run++;
        if (n_overlap !== 0) begin tests_failed++; $display("FAIL b2b_overlap: got %0d want 0", n_overlap); end
    endtask

    task automatic test_glitch();
        clear_counts();
        rx_raw = 1'b0;
        repeat (15) @(posedge clk_50M);
        #1;
        idle_bits(3);
        tests_run++;
        if (n_valid + n_ferr + n_perr !== 0) begin
            tests_failed++; $display("FAIL glitch_pulses: got %0d want 0", n_valid + n_ferr + n_perr);
        end
        tests_run++;
        if (busy_cycles !== HALF) begin tests_failed++; $display("FAIL glitch_busy_cycles: got %0d want %0d", busy_cycles, HALF); end
        tests_run++;
        if (rx_busy !== 1'b0) begin tests_failed++; $display("FAIL glitch_busy_after: got %b want 0", rx_busy); end
        tests_run++;
        if (data_out !== 8'h20) begin tests_failed++; $display("FAIL glitch_data_out: got %h want 20", data_out); end
    endtask

    task automatic test_framing();
        clear_counts();
        send_frame(8'h55, 1'b0, 1'b0);
        rx_raw = 1'b0;
        repeat (50 * CPB) @(posedge clk_50M);
        #1;
        tests_run++;
        if (n_ferr !== 1 || n_ferr_cyc !== 1) begin
            tests_failed++; $display("FAIL framing_pulse: got %0d pulses %0d cycles want 1 1", n_ferr, n_ferr_cyc);
        end
        tests_run++;
        if (rx_busy !== 1'b1) begin tests_failed++; $display("FAIL framing_busy_held: got %b want 1", rx_busy); end
        tests_run++;
        if (data_out !== 8'h20) begin tests_failed++; $display("FAIL framing_data_out: got %h want 20", data_out); end
        idle_bits(2);
        tests_run++;
        if (rx_busy !== 1'b0) begin tests_failed++; $display("FAIL framing_busy_release: got %b want 0", rx_busy); end
        tests_run++;
        if (n_valid + n_perr !== 0) begin tests_failed++; $display("FAIL framing_no_frame: got %0d want 0", n_valid + n_perr); end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] b;
        b = 8'hA5;
        clear_counts();
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(b[i]);
        rx_raw = b[4];
        repeat (CPB / 2) @(posedge clk_50M);
        #1;
        reset = 1'b1;
        rx_raw = 1'b1;
        repeat (3) @(posedge clk_50M);
        #1;
        reset = 1'b0;
        idle_bits(2);
        tests_run++;
        if (n_valid + n_ferr + n_perr !== 0) begin
            tests_failed++; $display("FAIL midreset_pulses: got %0d want 0", n_valid + n_ferr + n_perr);
        end
        tests_run++;
        if (rx_busy !== 1'b0) begin tests_failed++; $display("FAIL midreset_busy: got %b want 0", rx_busy); end
        send_byte(8'h3C);
        idle_bits(2);
        tests_run++;
        if (n_valid !== 1) begin tests_failed++; $display("FAIL midreset_resume_count: got %0d want 1", n_valid); end
        tests_run++;
        if (data_out !== 8'h3C) begin tests_failed++; $display("FAIL midreset_resume_data: got %h want 3c", data_out); end
    endtask

    task automatic test_parity();
`ifdef UART_RX_PARITY_EN
        clear_counts();
        send_frame(8'h07, 1'b0, 1'b1);
        idle_bits(2);
        tests_run++;
        if (n_perr !== 1 || n_perr_cyc !== 1) begin
            tests_failed++; $display("FAIL parity_bad_pulse: got %0d pulses %0d cycles want 1 1", n_perr, n_perr_cyc);
        end
        tests_run++;
        if (n_valid + n_ferr !== 0) begin tests_failed++; $display("FAIL parity_bad_other: got %0d want 0", n_valid + n_ferr); end
        tests_run++;
        if (data_out !== 8'h3C) begin tests_failed++; $display("FAIL parity_bad_data: got %h want 3c", data_out); end
        clear_counts();
        send_frame(8'h07, 1'b1, 1'b1);
        idle_bits(2);
        tests_run++;
        if (n_valid !== 1 || n_perr !== 0) begin
            tests_failed++; $display("FAIL parity_good: got valid %0d perr %0d want 1 0", n_valid, n_perr);
        end
        tests_run++;
        if (data_out !== 8'h07) begin tests_failed++; $display("FAIL parity_good_data: got %h want 07", data_out); end
`else
        clear_counts();
        send_frame(8'h07, 1'b0, 1'b1);
        idle_bits(2);
        tests_run++;
        if (n_perr_cyc !== 0) begin tests_failed++; $display("FAIL parity_tied_low: got %0d cycles want 0", n_perr_cyc); end
        tests_run++;
        if (data_out !== 8'h07 || n_valid !== 1) begin
            tests_failed++; $display("FAIL parity_absent_data: got %h (%0d) want 07 (1)", data_out, n_valid);
        end
`endif
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b1;
        rx_raw       = 1'b1;
        clear_counts();
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_glitch();
        test_framing();
        test_reset_midframe();
        test_parity();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, meaning input clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115_200, meaning line bit rate in bits/s.
REQ-003 SHALL have port clk_50M  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port rx_raw  input  1  asynchronous serial line, idle high.
REQ-006 SHALL have port data_out  output  8  last correctly received byte.
REQ-007 SHALL have port data_valid  output  1  one-cycle pulse when data_out is updated.
REQ-008 SHALL have port rx_busy  output  1  high from start-edge detection until return to IDLE.
REQ-009 SHALL have port framing_err  output  1  one-cycle pulse on a stop bit sampled low.
REQ-010 SHALL have port parity_err  output  1  one-cycle pulse on a parity mismatch; tied 0 when parity is compiled out.

Function
REQ-011 SHALL pass rx_raw through a 2-flop synchronizer (rx_sync); all decisions use rx_sync only.
REQ-012 SHALL derive CLKS_PER_BIT = CLK_FREQ/BAUD (integer, truncating; 434 at defaults) and HALF_BIT = CLKS_PER_BIT/2 (217).
REQ-013 SHALL use a 16-bit bit-timer counter; elaboration SHALL fail if CLKS_PER_BIT < 4 or > 65535.
REQ-014 SHALL implement states IDLE, START, DATA, PARITY (macro only), STOP, WAIT_HIGH.
REQ-015 IDLE: on rx_sync==0, clear timer, go to START, assert rx_busy.
REQ-016 START: at HALF_BIT cycles after entry, resample; rx_sync==1 -> false start, go to IDLE with no pulses; rx_sync==0 -> go to DATA.
REQ-017 DATA: sample every CLKS_PER_BIT cycles, shift in LSB first, 8 samples, then go to PARITY or STOP.
REQ-018 STOP: sample after CLKS_PER_BIT; 1 -> load data_out, pulse data_valid next cycle, go to IDLE; 0 -> pulse framing_err, leave data_out unchanged, go to WAIT_HIGH.
REQ-019 WAIT_HIGH: stay (rx_busy high) until rx_sync==1, then go to IDLE; a held-low break SHALL never produce a frame.
REQ-020 Return to IDLE at mid stop bit SHALL allow back-to-back frames with zero idle time.
REQ-021 data_valid, framing_err and parity_err SHALL be mutually exclusive and never high more than one cycle per frame.
REQ-022 Latency: data_valid SHALL rise HALF_BIT + 9*CLKS_PER_BIT + 1 cycles (+CLKS_PER_BIT with parity) after the cycle start is detected on rx_sync.
REQ-023 Illegal state encodings SHALL return to IDLE on the next cycle.

Reset
REQ-024 On reset: state IDLE, timer 0, data_out 8'h00, data_valid 0, rx_busy 0, framing_err 0, parity_err 0, synchronizer flops 1.
REQ-025 Reset mid-frame SHALL abort the frame with no pulse; reception resumes on the next falling edge after reset deasserts.

Configuration
REQ-026 Macro UART_RX_PARITY_EN defined: PARITY state samples one even-parity bit after data; mismatch -> pulse parity_err, discard byte, continue to STOP sampling for framing only (framing_err takes precedence, one pulse per frame).
REQ-027 Macro undefined: 8N1 only, PARITY state absent, parity_err constant 0.

Structure
REQ-028 Package uart_pkg SHALL hold state encodings, default CLK_FREQ/BAUD and the CLKS_PER_BIT/HALF_BIT derivation, shared with uart_tx.
REQ-029 SHALL instantiate one sub-module uart_sync (2-flop synchronizer, reset value 1); all else inline.

Verification
REQ-030 Send 0x48 ('H') 8N1 at 115200 -> data_out=0x48, data_valid one cycle at REQ-022 latency, rx_busy low after.
REQ-031 Send "Hello World!    " back-to-back, no idle -> 16 data_valid pulses, bytes in order, no errors.
REQ-032 Low glitch of 100 cycles on idle line -> no pulses, rx_busy high for about 217 cycles then low.
REQ-033 Frame 0x55 with stop bit 0, line then held low 2 ms -> one framing_err, data_out unchanged, no frame until line high.
REQ-034 Assert reset during bit 4 of 0xA5, then send 0x3C -> no pulse for 0xA5, data_out=0x3C valid.
REQ-035 With UART_RX_PARITY_EN, send 0x07 with parity bit 0 -> one parity_err pulse, no data_valid; correct parity 1 -> data_valid, data_out=0x07.
